// File: rtl/oursring_resp_rr_arbiter_pkg.sv
// Shared types and helpers for the oursring response arbiters.
package oursring_arb_pkg;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

  // Next index after idx, wrapping n-1 back to 0; always 0 for a single port.
  function automatic int idx_inc_wrap(input int idx, input int n);
    if ((n <= 1) || (idx + 1 >= n)) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/oursring_resp_rr_arbiter_if.sv
// R/B response bundle between the ring sources and the upstream master port.
interface oursring_resp_rr_arbiter_if #(
  parameter int N_IN_PORT  = 4,
  parameter int BEAT_CNT_W = 8,
  parameter int IDX_W      = (N_IN_PORT > 1) ? $clog2(N_IN_PORT) : 1
);
  logic [N_IN_PORT-1:0]  i_rvalid;
  logic [N_IN_PORT-1:0]  i_rlast;
  logic [N_IN_PORT-1:0]  i_rready;
  logic [N_IN_PORT-1:0]  i_bvalid;
  logic [N_IN_PORT-1:0]  i_bready;
  logic                  o_rready;
  logic                  o_rvalid;
  logic                  o_rlast;
  logic [IDX_W-1:0]      o_rsel;
  logic                  o_bready;
  logic                  o_bvalid;
  logic [IDX_W-1:0]      o_bsel;
  logic                  o_r_locked;
  logic [BEAT_CNT_W-1:0] o_rbeat_cnt;

  modport slave (
    input  i_rvalid, i_rlast, i_bvalid, o_rready, o_bready,
    output i_rready, i_bready, o_rvalid, o_rlast, o_rsel,
           o_bvalid, o_bsel, o_r_locked, o_rbeat_cnt
  );

  modport master (
    output i_rvalid, i_rlast, i_bvalid, o_rready, o_bready,
    input  i_rready, i_bready, o_rvalid, o_rlast, o_rsel,
           o_bvalid, o_bsel, o_r_locked, o_rbeat_cnt
  );
endinterface

// File: rtl/oursring_rr_pick.sv
// Combinational rotating-priority picker: first request at or after base wins.
module oursring_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    int               j;
    logic [IDX_W-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(base) + k;
      if (j >= N) begin
        j = j - N;
      end
      idx = IDX_W'(j);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/oursring_resp_rr_arbiter.sv
// Merges N response sources onto one R and one B channel; R bursts stay
// locked to their owner until RLAST, and the grant index steers the parent mux.
module oursring_resp_rr_arbiter
  import oursring_arb_pkg::*;
#(
  parameter int N_IN_PORT  = 4,
  parameter int RR_EN      = 1,
  parameter int BEAT_CNT_W = 8
) (
  input  logic clk,
  input  logic rstn,
  oursring_resp_rr_arbiter_if.slave bus
);

  localparam int IDX_W = (N_IN_PORT > 1) ? $clog2(N_IN_PORT) : 1;

  r_state_e              r_state_reg;
  logic [IDX_W-1:0]      r_ptr_reg;
  logic [IDX_W-1:0]      b_ptr_reg;
  logic [IDX_W-1:0]      r_owner_reg;
  logic [IDX_W-1:0]      r_hold_idx_reg;
  logic [IDX_W-1:0]      b_hold_idx_reg;
  logic                  r_hold_vld_reg;
  logic                  b_hold_vld_reg;
  logic [BEAT_CNT_W-1:0] beat_cnt_reg;

  logic [N_IN_PORT-1:0]  owner_mask;
  logic [N_IN_PORT-1:0]  r_req;
  logic [N_IN_PORT-1:0]  r_gnt;
  logic [N_IN_PORT-1:0]  b_gnt;
  logic [IDX_W-1:0]      r_base;
  logic [IDX_W-1:0]      b_base;
  logic [IDX_W-1:0]      r_sel;
  logic [IDX_W-1:0]      b_sel;
  logic [IDX_W-1:0]      r_sel_inc;
  logic [IDX_W-1:0]      b_sel_inc;
  logic                  r_any;
  logic                  b_any;
  logic                  r_last;
  logic                  r_hs;
  logic                  b_hs;

  for (genvar gi = 0; gi < N_IN_PORT; gi++) begin : g_owner_mask
    assign owner_mask[gi] = (r_owner_reg == IDX_W'(gi));
  end

  // A stalled idle grant is re-offered first, so a newly rising higher-priority
  // valid cannot steal it before the upstream accepts.
  always_comb begin
    r_req  = bus.i_rvalid;
    r_base = r_hold_vld_reg ? r_hold_idx_reg : r_ptr_reg;
    if (r_state_reg == R_BURST) begin
      r_req  = bus.i_rvalid & owner_mask;
      r_base = r_owner_reg;
    end
  end

  assign b_base = b_hold_vld_reg ? b_hold_idx_reg : b_ptr_reg;

  oursring_rr_pick #(.N(N_IN_PORT), .IDX_W(IDX_W)) u_r_pick (
    .req     (r_req),
    .base    (r_base),
    .gnt     (r_gnt),
    .gnt_idx (r_sel),
    .any     (r_any)
  );

  oursring_rr_pick #(.N(N_IN_PORT), .IDX_W(IDX_W)) u_b_pick (
    .req     (bus.i_bvalid),
    .base    (b_base),
    .gnt     (b_gnt),
    .gnt_idx (b_sel),
    .any     (b_any)
  );

  assign r_last    = r_any & bus.i_rlast[r_sel];
  assign r_hs      = r_any & bus.o_rready;
  assign b_hs      = b_any & bus.o_bready;
  assign r_sel_inc = IDX_W'(idx_inc_wrap(int'(r_sel), N_IN_PORT));
  assign b_sel_inc = IDX_W'(idx_inc_wrap(int'(b_sel), N_IN_PORT));

  assign bus.o_rvalid    = r_any;
  assign bus.o_rlast     = r_last;
  assign bus.o_rsel      = r_sel;
  assign bus.i_rready    = r_gnt & {N_IN_PORT{bus.o_rready}};
  assign bus.o_bvalid    = b_any;
  assign bus.o_bsel      = b_sel;
  assign bus.i_bready    = b_gnt & {N_IN_PORT{bus.o_bready}};
  assign bus.o_r_locked  = (r_state_reg == R_BURST);
  assign bus.o_rbeat_cnt = beat_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state_reg    <= R_IDLE;
      r_ptr_reg      <= '0;
      r_owner_reg    <= '0;
      r_hold_idx_reg <= '0;
      r_hold_vld_reg <= 1'b0;
      beat_cnt_reg   <= '0;
    end else begin
      r_hold_vld_reg <= (r_state_reg == R_IDLE) && r_any && !bus.o_rready;
      r_hold_idx_reg <= r_sel;
      case (r_state_reg)
        R_IDLE: begin
          if (r_hs) begin
            if (r_last) begin
              r_ptr_reg <= (RR_EN != 0) ? r_sel_inc : '0;
            end else begin
              r_state_reg  <= R_BURST;
              r_owner_reg  <= r_sel;
              beat_cnt_reg <= BEAT_CNT_W'(1);
            end
          end
        end
        R_BURST: begin
          if (r_hs) begin
            if (r_last) begin
              r_state_reg  <= R_IDLE;
              beat_cnt_reg <= '0;
              r_ptr_reg    <= (RR_EN != 0) ? r_sel_inc : '0;
            end else if (beat_cnt_reg != '1) begin
              beat_cnt_reg <= beat_cnt_reg + BEAT_CNT_W'(1);
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      b_ptr_reg      <= '0;
      b_hold_idx_reg <= '0;
      b_hold_vld_reg <= 1'b0;
    end else begin
      b_hold_vld_reg <= b_any && !bus.o_bready;
      b_hold_idx_reg <= b_sel;
      if (b_hs && (RR_EN != 0)) begin
        b_ptr_reg <= b_sel_inc;
      end
    end
  end

`ifndef SYNTHESIS
  a_rready_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(bus.i_rready));
  a_bready_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(bus.i_bready));
`endif

endmodule
